// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: data word, RAM status codes and arbiter states.
// No logic; imported by the memory arbiter and its neighbours.
// Encodings of ramstate_t match the RAM controller's 2-bit status bus.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_D = 2'd1,
    SERVE_I = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Purpose: grants the single RAM port to the dcache (priority) or the icache, with a starvation bound for the icache.
// Latency: grant registered in IDLE; RAM driven from the next cycle; minimum 2 cycles request-to-completion.
// Backpressure: requester's wait stays 1 until RAM ACCESS; FREE/BUSY hold the grant, ERROR retries, withdrawal aborts.
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  output logic              iwait,
  output logic              dwait,
  output logic [ADDR_W-1:0] iload,
  output logic [ADDR_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       mem_err_q, mem_err_d;
  logic       dreq;
  ramstate_t  rs;

  assign dreq    = dREN | dWEN;
  assign rs      = ramstate_t'(ramstate);
  assign mem_err = mem_err_q;

  // State, starvation counter and error pulse registers; reset drops the grant at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_err_q    <= mem_err_d;
    end
  end

  // Arbitration, RAM port steering and completion/abort/error handling.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_err_d    = 1'b0;
    iwait        = 1'b1;
    dwait        = 1'b1;
    iload        = '0;
    dload        = '0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;

    unique case (state_q)
      IDLE: begin
        // The icache jumps the queue only once the dcache has had its run.
        if (iREN && (starve_cnt_q == STARVE_LIM)) begin
          state_d = SERVE_I;
        end else if (dreq) begin
          state_d = SERVE_D;
        end else if (iREN) begin
          state_d = SERVE_I;
        end
      end

      SERVE_D: begin
        if (!dreq) begin
          // Withdrawn: nothing is driven and no completion is reported.
          state_d = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (rs == ACCESS) begin
            dwait   = 1'b0;
            if (!dWEN) begin
              dload = ramload;
            end
            state_d = IDLE;
            if (iREN) begin
              if (starve_cnt_q < STARVE_LIM) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
              end
            end else begin
              starve_cnt_d = 4'd0;
            end
          end else if (rs == ERROR) begin
            state_d   = IDLE;
            mem_err_d = 1'b1;
          end
        end
      end

      SERVE_I: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (rs == ACCESS) begin
            iwait        = 1'b0;
            iload        = ramload;
            state_d      = IDLE;
            starve_cnt_d = 4'd0;
          end else if (rs == ERROR) begin
            state_d   = IDLE;
            mem_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed table-driven bench for cache_mem_arbiter plus hand sequences
// for withdrawal and asynchronous reset mid-transaction.
// Inputs change on the falling edge; outputs are checked 2 ns later.
module tb_cache_mem_arbiter;

  localparam logic [1:0] RF = 2'd0;
  localparam logic [1:0] RB = 2'd1;
  localparam logic [1:0] RA = 2'd2;
  localparam logic [1:0] RE = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, mem_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_cmp = 0;
  int n_bad = 0;

  cache_mem_arbiter #(.STARVE_MAX(4), .ADDR_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ir, dr, dw;
    logic [31:0] ia, da, ds;
    logic [1:0]  rs;
    logic [31:0] rl;
    logic        e_iw, e_dw, e_rr, e_rw;
    logic [31:0] e_ra, e_rst, e_il, e_dl;
    logic        e_me;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    input logic ir, dr, dw,
    input logic [31:0] ia, da, ds,
    input logic [1:0] rs,
    input logic [31:0] rl,
    input logic iw, dwo, rr, rw,
    input logic [31:0] ra, rst, il, dl,
    input logic me);
    vec_t t;
    t.ir = ir; t.dr = dr; t.dw = dw; t.ia = ia; t.da = da; t.ds = ds;
    t.rs = rs; t.rl = rl;
    t.e_iw = iw; t.e_dw = dwo; t.e_rr = rr; t.e_rw = rw;
    t.e_ra = ra; t.e_rst = rst; t.e_il = il; t.e_dl = dl; t.e_me = me;
    return t;
  endfunction

  // Inputs with idle-state expectations (both waits high, RAM port quiet).
  function automatic vec_t vi(
    input logic ir, dr, dw,
    input logic [31:0] ia, da, ds,
    input logic [1:0] rs,
    input logic me);
    return v(ir, dr, dw, ia, da, ds, rs, 32'h0, 1, 1, 0, 0, 0, 0, 0, 0, me);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    iREN = t.ir; dREN = t.dr; dWEN = t.dw;
    iaddr = t.ia; daddr = t.da; dstore = t.ds;
    ramstate = t.rs; ramload = t.rl;
  endtask

  task automatic check_outs(input string tag, input vec_t t);
    chk({tag, ".iwait"},    32'(iwait),    32'(t.e_iw));
    chk({tag, ".dwait"},    32'(dwait),    32'(t.e_dw));
    chk({tag, ".ramREN"},   32'(ramREN),   32'(t.e_rr));
    chk({tag, ".ramWEN"},   32'(ramWEN),   32'(t.e_rw));
    chk({tag, ".ramaddr"},  ramaddr,       t.e_ra);
    chk({tag, ".ramstore"}, ramstore,      t.e_rst);
    chk({tag, ".iload"},    iload,         t.e_il);
    chk({tag, ".dload"},    dload,         t.e_dl);
    chk({tag, ".mem_err"},  32'(mem_err),  32'(t.e_me));
  endtask

  task automatic apply(input string tag, input vec_t t);
    @(negedge CLK);
    drive(t);
    #2;
    check_outs(tag, t);
  endtask

  initial begin
    vec_t t;
    logic [31:0] rl;
    string pat;

    nRST = 1'b0;
    drive(vi(0, 0, 0, 0, 0, 0, RF, 0));
    #2;
    check_outs("reset", vi(0, 0, 0, 0, 0, 0, RF, 0));
    #5 nRST = 1'b1;

    // Isolated icache read: BUSY, BUSY, ACCESS.
    vecs.push_back(vi(1, 0, 0, 32'h100, 0, 0, RF, 0));
    vecs.push_back(v(1, 0, 0, 32'h100, 0, 0, RB, 0, 1, 1, 1, 0, 32'h100, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 32'h100, 0, 0, RB, 0, 1, 1, 1, 0, 32'h100, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 32'h100, 0, 0, RA, 32'hDEADBEEF,
                     0, 1, 1, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0));
    vecs.push_back(vi(0, 0, 0, 0, 0, 0, RF, 0));

    // Simultaneous icache read and dcache write: dcache first, bubble, then icache.
    vecs.push_back(vi(1, 0, 1, 32'h300, 32'h200, 32'hCAFE0001, RF, 0));
    vecs.push_back(v(1, 0, 1, 32'h300, 32'h200, 32'hCAFE0001, RB, 0,
                     1, 1, 0, 1, 32'h200, 32'hCAFE0001, 0, 0, 0));
    vecs.push_back(v(1, 0, 1, 32'h300, 32'h200, 32'hCAFE0001, RA, 32'h12345678,
                     1, 0, 0, 1, 32'h200, 32'hCAFE0001, 0, 0, 0));
    vecs.push_back(vi(1, 0, 0, 32'h300, 32'h200, 32'hCAFE0001, RF, 0));
    vecs.push_back(v(1, 0, 0, 32'h300, 32'h200, 32'hCAFE0001, RA, 32'hA5A5A5A5,
                     0, 1, 1, 0, 32'h300, 0, 32'hA5A5A5A5, 0, 0));
    vecs.push_back(vi(0, 0, 0, 0, 0, 0, RF, 0));

    // Starvation bound: both held high, 1-cycle accesses. Four dcache grants,
    // then the icache; the second round proves the counter went back to 0.
    pat = "DDDDIDDDDI";
    for (int k = 0; k < pat.len(); k++) begin
      rl = 32'h1000 + 32'(k);
      vecs.push_back(vi(1, 1, 0, 32'h600, 32'h500, 32'h77, RA, 0));
      if (pat[k] == "D")
        vecs.push_back(v(1, 1, 0, 32'h600, 32'h500, 32'h77, RA, rl,
                         1, 0, 1, 0, 32'h500, 32'h77, 0, rl, 0));
      else
        vecs.push_back(v(1, 1, 0, 32'h600, 32'h500, 32'h77, RA, rl,
                         0, 1, 1, 0, 32'h600, 0, rl, 0, 0));
    end
    vecs.push_back(vi(0, 0, 0, 0, 0, 0, RF, 0));

    // ERROR retry: error pulse the cycle after, bubble, regrant, completion.
    vecs.push_back(vi(0, 1, 0, 0, 32'h40, 0, RF, 0));
    vecs.push_back(v(0, 1, 0, 0, 32'h40, 0, RE, 0, 1, 1, 1, 0, 32'h40, 0, 0, 0, 0));
    vecs.push_back(vi(0, 1, 0, 0, 32'h40, 0, RF, 1));
    vecs.push_back(v(0, 1, 0, 0, 32'h40, 0, RA, 32'hBEEF0040,
                     1, 0, 1, 0, 32'h40, 0, 0, 32'hBEEF0040, 0));
    vecs.push_back(vi(0, 0, 0, 0, 0, 0, RF, 0));

    // Read and write together: write wins, no load returned.
    vecs.push_back(vi(0, 1, 1, 0, 32'h80, 32'h55, RF, 0));
    vecs.push_back(v(0, 1, 1, 0, 32'h80, 32'h55, RA, 32'h99,
                     1, 0, 0, 1, 32'h80, 32'h55, 0, 0, 0));
    vecs.push_back(vi(0, 0, 0, 0, 0, 0, RF, 0));

    foreach (vecs[i]) apply($sformatf("row%0d", i), vecs[i]);

    // Withdrawal of an icache read while BUSY; counter left at 1 beforehand.
    apply("wd0", vi(1, 1, 0, 32'h600, 32'h500, 0, RF, 0));
    apply("wd1", v(1, 1, 0, 32'h600, 32'h500, 0, RA, 32'hCC,
                   1, 0, 1, 0, 32'h500, 0, 0, 32'hCC, 0));
    apply("wd2", vi(1, 0, 0, 32'h600, 32'h500, 0, RF, 0));
    apply("wd3", v(1, 0, 0, 32'h600, 32'h500, 0, RB, 0,
                   1, 1, 1, 0, 32'h600, 0, 0, 0, 0));
    #1 iREN = 1'b0;
    #1;
    chk("wd.drop_ramREN", 32'(ramREN), 32'h0);
    chk("wd.drop_iwait",  32'(iwait),  32'h1);
    apply("wd4", vi(0, 0, 0, 0, 0, 0, RF, 0));
    chk("wd.state",  32'(dut.state_q),      32'h0);
    chk("wd.starve", 32'(dut.starve_cnt_q), 32'h1);

    // Asynchronous reset in the middle of a dcache write.
    apply("rst0", vi(0, 0, 1, 0, 32'hA00, 32'h5A5A, RF, 0));
    apply("rst1", v(0, 0, 1, 0, 32'hA00, 32'h5A5A, RB, 0,
                    1, 1, 0, 1, 32'hA00, 32'h5A5A, 0, 0, 0));
    #1 nRST = 1'b0;
    #1;
    chk("rst.ramWEN_async", 32'(ramWEN),  32'h0);
    chk("rst.ramaddr",      ramaddr,      32'h0);
    chk("rst.dwait",        32'(dwait),   32'h1);
    @(negedge CLK);
    t = vi(0, 0, 0, 0, 0, 0, RF, 0);
    drive(t);
    nRST = 1'b1;
    #2;
    check_outs("rst2", t);
    chk("rst.state", 32'(dut.state_q), 32'h0);

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Arbitrates the icache and dcache miss/writeback traffic onto the single shared RAM port.
- Sits between the cache block (icache + dcache) and the RAM.
- One requester is granted at a time.
- dcache has priority, with a bounded-starvation guarantee for the icache.
- The grant is held until the RAM reports ACCESS, the requester withdraws, or the RAM reports ERROR.

Parameters:
STARVE_MAX, 4, consecutive dcache completions (with iREN pending) after which the icache is forced ahead of the dcache; range 1..15
ADDR_W, 32, address and data width (word_t)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  icache read request
iaddr  in  32  icache read address
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  32  dcache address
dstore  in  32  dcache write data
iwait  out  1  icache stall; 0 only in the icache completion cycle
dwait  out  1  dcache stall; 0 only in the dcache completion cycle
iload  out  32  icache read data
dload  out  32  dcache read data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
mem_err  out  1  one-cycle registered pulse, asserted the cycle after ramstate==ERROR is seen during a grant

Behaviour:
- Reset is asynchronous, active low. On reset:
  - state=IDLE, starve_cnt=0, mem_err=0.
  - Combinational outputs then hold iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
- States: IDLE, SERVE_D, SERVE_I. The state register updates on the CLK edge only.
- Arbitration, evaluated in IDLE only:
  - Let dreq = dREN|dWEN.
  - If iREN and starve_cnt==STARVE_MAX, go to SERVE_I.
  - Else if dreq, go to SERVE_D.
  - Else if iREN, go to SERVE_I.
  - Else stay in IDLE.
- Latency: the grant is registered. A request seen in IDLE drives the RAM from the next cycle. Minimum request-to-completion latency is 2 cycles (grant cycle plus one ACCESS cycle).
- In SERVE_D:
  - ramaddr=daddr, ramstore=dstore.
  - If dWEN=1, then ramWEN=1 and ramREN=0; write wins when dREN and dWEN are both high.
  - Else ramREN=dREN.
  - iwait=1, iload=0.
- In SERVE_I:
  - ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
  - dwait=1, dload=0.
- Completion: ramstate==ACCESS while serving X.
  - In that same cycle, Xwait=0; for a read, Xload=ramload.
  - Next state is IDLE.
  - The IDLE bubble is mandatory: the requester's enable may still be high in the completion cycle and must not re-trigger a duplicate grant.
- FREE/BUSY while serving: hold the grant and hold the RAM outputs stable; the requester's wait stays 1.
- ERROR while serving:
  - The requester's wait stays 1.
  - Next state is IDLE, so the request is retried via normal arbitration.
  - mem_err=1 for exactly the next cycle.
- Requester withdrawal:
  - Serving D with dREN=dWEN=0, or serving I with iREN=0, means abort.
  - RAM enables go to 0 that same cycle (combinationally), the wait output stays 1, and next state is IDLE.
  - No completion is reported, even if ramstate==ACCESS that cycle.
- starve_cnt (4-bit, saturating at STARVE_MAX):
  - Increments on each dcache completion while iREN=1.
  - Clears on every icache completion.
  - Clears on any dcache completion with iREN=0.
  - Holds otherwise.
- Outside the grant: the non-granted requester's wait is 1 and its load is 0. In IDLE both waits are 1 and the RAM enables are 0.
- Reset mid-transaction: everything returns to reset values immediately; the RAM enables drop asynchronously.

Decomposition:
- cpu_types_pkg (shared package) holds:
  - word_t
  - ramstate_t enum (FREE, BUSY, ACCESS, ERROR)
  - arb_state_t enum (IDLE, SERVE_D, SERVE_I)
- Single flat module; no sub-module warranted.
- Wrapping in caches_if is left to the integrating top level.

Test Plan:
- Isolated I read: iREN=1, iaddr=0x100, ramstate BUSY×2 then ACCESS with ramload=0xDEADBEEF -> ramREN=1 from cycle 1; iwait=0 and iload=0xDEADBEEF only in the ACCESS cycle; IDLE next.
- Simultaneous requests: iREN=1 and dWEN=1 (daddr=0x200, dstore=0xCAFE0001) in the same cycle -> SERVE_D first with ramWEN=1 and ramstore=0xCAFE0001; after dwait=0, one IDLE cycle, then SERVE_I.
- Starvation bound, STARVE_MAX=4: dREN and iREN held high, every access completes in 1 cycle -> exactly 4 dcache completions, then the icache is granted; starve_cnt returns to 0.
- ERROR retry: dREN=1, daddr=0x40, ramstate=ERROR once then ACCESS -> mem_err pulses 1 cycle; dwait stays 1 through the error; re-grant after IDLE; dwait=0 on ACCESS.
- Withdrawal: SERVE_I with ramstate=BUSY, iREN drops -> ramREN=0 in the same cycle, iwait=1, IDLE next, starve_cnt unchanged.
- Async reset mid-SERVE_D (ramWEN=1) -> ramWEN=0 without waiting for CLK; after release, state=IDLE and mem_err=0.
